// File: rtl/alu_req_arbiter.sv
// alu_req_arbiter
// Round-robin arbiter and sequencer sharing one small ALU between four
// requesters. One operation is in flight at a time: the winner's op and
// operands are latched onto the ALU inputs at grant, the result is captured
// ALU_LAT cycles later and returned tagged with the requester index.
//
// Ports:
//   clk_i      clock, rising edge
//   rst_n_i    synchronous active-low reset
//   req_i      per-requester request, bit n = requester n
//   op_i       packed 2-bit ops, requester n at [2n+1:2n]
//   a_i, b_i   packed 4-bit operands, requester n at [4n+3:4n]
//   gnt_o      one-hot, one-cycle grant pulse
//   alu_sel_o  ALU op / result-mux select
//   alu_a_o    ALU operand A
//   alu_b_o    ALU operand B
//   alu_y_i    ALU result
//   done_o     one-cycle result-valid pulse
//   done_id_o  requester index of result_o
//   result_o   captured ALU result
//   busy_o     high while an operation is in flight

module alu_req_arbiter #(
    parameter int unsigned ALU_LAT = 1
) (
    input  logic       clk_i,
    input  logic       rst_n_i,
    input  logic [3:0] req_i,
    input  logic [7:0] op_i,
    input  logic [15:0] a_i,
    input  logic [15:0] b_i,
    output logic [3:0] gnt_o,
    output logic [1:0] alu_sel_o,
    output logic [3:0] alu_a_o,
    output logic [3:0] alu_b_o,
    input  logic [7:0] alu_y_i,
    output logic       done_o,
    output logic [1:0] done_id_o,
    output logic [7:0] result_o,
    output logic       busy_o
);

    // Counter is loaded with ALU_LAT-1 so the capture lands on edge E+ALU_LAT.
    localparam logic [3:0] CntInit = 4'(ALU_LAT - 1);

    typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

    state_e     state_q, state_d;
    logic [1:0] rr_ptr_q;
    logic [3:0] cnt_q;
    logic [1:0] id_q;
    logic [3:0] gnt_q;
    logic [1:0] sel_q;
    logic [3:0] a_q;
    logic [3:0] b_q;
    logic [7:0] result_q;
    logic [1:0] done_id_q;

    logic       win_vld;
    logic [1:0] win_id;
    logic [1:0] cand;

    // Scan upward from the round-robin pointer, wrapping 3->0.
    always_comb begin
        win_vld = 1'b0;
        win_id  = rr_ptr_q;
        cand    = rr_ptr_q;
        for (int i = 0; i < 4; i++) begin
            cand = rr_ptr_q + 2'(i);
            if (!win_vld && req_i[cand]) begin
                win_vld = 1'b1;
                win_id  = cand;
            end
        end
    end

    // State register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (win_vld) state_d = StExec;
            StExec:  if (cnt_q == 4'd0) state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Outputs decoded from state
    always_comb begin
        busy_o = (state_q != StIdle);
        done_o = (state_q == StDone);
    end

    // Datapath: grant, ALU input latches, latency counter, result capture.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            rr_ptr_q  <= 2'd0;
            cnt_q     <= 4'd0;
            id_q      <= 2'd0;
            gnt_q     <= 4'd0;
            sel_q     <= 2'd0;
            a_q       <= 4'd0;
            b_q       <= 4'd0;
            result_q  <= 8'd0;
            done_id_q <= 2'd0;
        end else begin
            gnt_q <= 4'd0;
            case (state_q)
                StIdle: begin
                    if (win_vld) begin
                        gnt_q    <= 4'b0001 << win_id;
                        sel_q    <= op_i[{win_id, 1'b0} +: 2];
                        a_q      <= a_i[{win_id, 2'b00} +: 4];
                        b_q      <= b_i[{win_id, 2'b00} +: 4];
                        id_q     <= win_id;
                        cnt_q    <= CntInit;
                        rr_ptr_q <= win_id + 2'd1;
                    end
                end
                StExec: begin
                    if (cnt_q != 4'd0) begin
                        cnt_q <= cnt_q - 4'd1;
                    end else begin
                        result_q  <= alu_y_i;
                        done_id_q <= id_q;
                    end
                end
                default: ;
            endcase
        end
    end

    assign gnt_o     = gnt_q;
    assign alu_sel_o = sel_q;
    assign alu_a_o   = a_q;
    assign alu_b_o   = b_q;
    assign result_o  = result_q;
    assign done_id_o = done_id_q;

endmodule
